serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: DIFF = A - B - Bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output OVF is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, borrow_q;
  logic             accept, last;
  logic             a0, b0, d_bit, br_out;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs plus the registered borrow.
  assign a0       = a_sr_q[0];
  assign b0       = b_sr_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_out   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign res_next = WIDTH'({d_bit, res_sr_q} >> 1);
  assign last     = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          accept  = 1'b1;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = SHIFT;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr_q   <= A;
        b_sr_q   <= B;
        br_q     <= Bin;
        cnt_q    <= '0;
        res_sr_q <= '0;
      end else if (state_q == SHIFT) begin
        a_sr_q   <= a_sr_q >> 1;
        b_sr_q   <= b_sr_q >> 1;
        br_q     <= br_out;
        res_sr_q <= res_next;
        cnt_q    <= cnt_q + CW'(1);
        if (last) begin
          diff_q   <= res_next;
          borrow_q <= br_out;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // The last bits processed are the operand sign bits and the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (a0 ^ b0) & (a0 ^ d_bit);
    end
  end
  assign OVF = ovf_q;
`endif

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, timing/corner
// sequences, and random operands against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         bin_in = 1'b0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] held_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Bin   (bin_in),
    .busy  (busy),
    .done  (done),
    .DIFF  (diff),
    .BORROW(borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned borrow/difference and signed overflow from plain arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic br, output logic ov);
    logic [W:0] full;
    int         s;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = full[W-1:0];
    br   = full[W];
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov   = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endtask

  // Drive a request now (just after an edge); it is sampled at the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    a_in   = a;
    b_in   = b;
    bin_in = bin;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Called one cycle after the accepting edge; checks busy window, done pulse and result.
  // inject>0 re-asserts start (with other operands) in that busy cycle to prove it is ignored.
  task automatic wait_result(input logic [W-1:0] ed, input logic eb, input logic eo,
                             input int inject);
    for (int i = 1; i <= W; i++) begin
      if (i == inject) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("busy_c%0d", i), {31'b0, busy}, 32'd1);
      chk($sformatf("done_low_c%0d", i), {31'b0, done}, 32'd0);
      chk($sformatf("diff_held_c%0d", i), {24'b0, diff}, {24'b0, held_diff});
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("diff", {24'b0, diff}, {24'b0, ed});
    chk("borrow", {31'b0, borrow}, {31'b0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", {31'b0, ovf}, {31'b0, eo});
`else
    if (eo === 1'bx) $display("note: unknown expected overflow");
`endif
    held_diff = ed;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("diff_held_idle", {24'b0, diff}, {24'b0, held_diff});
  endtask

  initial begin
    vec_t         vecs[7];
    logic [W-1:0] md;
    logic         mb, mo;
    logic [W-1:0] ra, rb;
    logic         rbin;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_diff", {24'b0, diff}, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table (includes the directed scenarios 1-4 operands)
    for (int v = 0; v < 7; v++) begin
      start_op(vecs[v].a, vecs[v].b, vecs[v].bin);
      wait_result(vecs[v].exp_diff, vecs[v].exp_borrow, vecs[v].exp_ovf, 0);
      idle_check();
    end

    // Back-to-back: start during DONE
    start_op(8'h10, 8'h10, 1'b1);
    wait_result(8'hFF, 1'b1, 1'b0, 0);
    start_op(8'h03, 8'h01, 1'b0);
    wait_result(8'h02, 1'b0, 1'b0, 0);
    idle_check();

    // start in SHIFT is ignored
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_result(8'h1E, 1'b0, 1'b0, 4);
    idle_check();
    idle_check();

    // Reset mid-operation
    start_op(8'h00, 8'h01, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    held_diff = '0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_diff", {24'b0, diff}, 32'd0);
    chk("midrst_borrow", {31'b0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("midrst_ovf", {31'b0, ovf}, 32'd0);
`endif
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_result(8'h1E, 1'b0, 1'b0, 0);

    // Random operands, chained back-to-back through the DONE cycle
    for (int r = 0; r < 1000; r++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, md, mb, mo);
      start_op(ra, rb, rbin);
      wait_result(md, mb, mo, 0);
    end
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
